control_unit_fsm: RTL and testbench



---
 rtl/control_unit_fsm.sv | 236 +++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit for the cs147sec05 processor. Every instruction
// walks FETCH, DECODE, EXE, MEM and WB. Decoding is purely combinational
// from INSTRUCTION, and the state register only tracks the phase.
module control_unit_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ZERO,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] CTRL,
  output logic        READ,
  output logic        WRITE,
  output logic        HALTED
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  // Control word bit positions
  localparam int PC_LOAD   = 0;
  localparam int PC_SEL_1  = 1;
  localparam int PC_SEL_2  = 2;
  localparam int PC_SEL_3  = 3;
  localparam int IR_LOAD   = 4;
  localparam int MEM_R     = 5;
  localparam int MEM_W     = 6;
  localparam int R1_SEL_1  = 7;
  localparam int REG_R     = 8;
  localparam int REG_W     = 9;
  localparam int WA_SEL_1  = 10;
  localparam int WA_SEL_2  = 11;
  localparam int WA_SEL_3  = 12;
  localparam int WD_SEL_1  = 13;
  localparam int WD_SEL_2  = 14;
  localparam int WD_SEL_3  = 15;
  localparam int SP_LOAD   = 16;
  localparam int OP1_SEL_1 = 17;
  localparam int OP2_SEL_1 = 18;
  localparam int OP2_SEL_2 = 19;
  localparam int OP2_SEL_3 = 20;
  localparam int OP2_SEL_4 = 21;
  localparam int ALU_LSB   = 22;
  localparam int MA_SEL_1  = 26;
  localparam int MA_SEL_2  = 27;
  localparam int MD_SEL_1  = 28;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  state_t state_q, state_d;

  logic [5:0]  opcode, funct;
  logic        unused_ir;
  logic        legal;
  logic [31:0] hold;     // operand selects / ALU code held from EXE to WB
  logic        wr_rd, wr_rt;
  logic        is_lw, is_sw, is_push, is_pop, is_beq, is_bne;
  logic        is_jr, is_jmp, is_jal, is_lui;

  assign opcode    = INSTRUCTION[31:26];
  assign funct     = INSTRUCTION[5:0];
  assign unused_ir = ^INSTRUCTION[25:6];

  // State register: reset always restarts at FETCH
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state: fixed five-phase ring, HALT is entered only from DECODE
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (!legal && HALT_ON_ILLEGAL) ? S_HALT : S_EXE;
      S_EXE:    state_d = S_MEM;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Instruction decode into held datapath selects and per-class flags
  always_comb begin
    legal   = 1'b1;
    hold    = '0;
    wr_rd   = 1'b0;
    wr_rt   = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jr   = 1'b0;
    is_jmp  = 1'b0;
    is_jal  = 1'b0;
    is_lui  = 1'b0;
    case (opcode)
      6'h00: begin
        wr_rd = 1'b1;
        hold[OP2_SEL_4] = 1'b1;
        case (funct)
          6'h20: hold[ALU_LSB +: 4] = ALU_ADD;
          6'h22: hold[ALU_LSB +: 4] = ALU_SUB;
          6'h2c: hold[ALU_LSB +: 4] = ALU_MUL;
          6'h24: hold[ALU_LSB +: 4] = ALU_AND;
          6'h25: hold[ALU_LSB +: 4] = ALU_OR;
          6'h27: hold[ALU_LSB +: 4] = ALU_NOR;
          6'h2a: hold[ALU_LSB +: 4] = ALU_SLT;
          6'h01, 6'h02: begin
            // shifts take shamt instead of R2
            hold[OP2_SEL_4]     = 1'b0;
            hold[OP2_SEL_3]     = 1'b1;
            hold[OP2_SEL_1]     = 1'b1;
            hold[ALU_LSB +: 4]  = (funct == 6'h01) ? ALU_SLL : ALU_SRL;
          end
          6'h08: begin
            wr_rd = 1'b0;
            hold  = '0;
            is_jr = 1'b1;
          end
          default: begin
            wr_rd = 1'b0;
            hold  = '0;
            legal = 1'b0;
          end
        endcase
      end
      6'h08: begin hold[OP2_SEL_2] = 1'b1; hold[ALU_LSB +: 4] = ALU_ADD; wr_rt = 1'b1; end
      6'h1d: begin hold[OP2_SEL_2] = 1'b1; hold[ALU_LSB +: 4] = ALU_MUL; wr_rt = 1'b1; end
      6'h0a: begin hold[OP2_SEL_2] = 1'b1; hold[ALU_LSB +: 4] = ALU_SLT; wr_rt = 1'b1; end
      6'h0c: begin hold[ALU_LSB +: 4] = ALU_AND; wr_rt = 1'b1; end
      6'h0d: begin hold[ALU_LSB +: 4] = ALU_OR;  wr_rt = 1'b1; end
      6'h0f: begin is_lui = 1'b1; wr_rt = 1'b1; end
      6'h04, 6'h05: begin
        // compare rs with rt; the sign-extended offset feeds the branch adder
        hold[OP2_SEL_4]    = 1'b1;
        hold[OP2_SEL_2]    = 1'b1;
        hold[ALU_LSB +: 4] = ALU_SUB;
        is_beq = (opcode == 6'h04);
        is_bne = (opcode == 6'h05);
      end
      6'h23: begin hold[OP2_SEL_2] = 1'b1; hold[ALU_LSB +: 4] = ALU_ADD; wr_rt = 1'b1; is_lw = 1'b1; end
      6'h2b: begin hold[OP2_SEL_2] = 1'b1; hold[ALU_LSB +: 4] = ALU_ADD; is_sw = 1'b1; end
      6'h02: is_jmp = 1'b1;
      6'h03: is_jal = 1'b1;
      6'h1b: begin
        // SP-1 computed on SP with constant 1; R0 driven as store data
        hold[OP1_SEL_1]    = 1'b1;
        hold[OP2_SEL_3]    = 1'b1;
        hold[ALU_LSB +: 4] = ALU_SUB;
        hold[R1_SEL_1]     = 1'b1;
        hold[MD_SEL_1]     = 1'b1;
        is_push = 1'b1;
      end
      6'h1c: begin
        hold[OP1_SEL_1]    = 1'b1;
        hold[OP2_SEL_3]    = 1'b1;
        hold[ALU_LSB +: 4] = ALU_ADD;
        is_pop = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Outputs: per-phase control word, all quiet while reset is held
  always_comb begin
    CTRL   = '0;
    READ   = 1'b0;
    WRITE  = 1'b0;
    HALTED = 1'b0;
    if (!RST) begin
      case (state_q)
        S_FETCH: begin
          CTRL[MEM_R]    = 1'b1;
          CTRL[MA_SEL_2] = 1'b1;
          READ           = 1'b1;
        end
        S_DECODE: begin
          CTRL[MEM_R]    = 1'b1;
          CTRL[MA_SEL_2] = 1'b1;
          CTRL[IR_LOAD]  = 1'b1;
          CTRL[REG_R]    = 1'b1;
          READ           = 1'b1;
        end
        S_EXE: begin
          CTRL          = hold;
          CTRL[REG_R]   = 1'b1;
          CTRL[SP_LOAD] = is_pop;
        end
        S_MEM: begin
          CTRL           = hold;
          CTRL[MEM_R]    = is_lw | is_pop;
          CTRL[MEM_W]    = is_sw | is_push;
          CTRL[MA_SEL_1] = is_push | is_pop;
          READ           = is_lw | is_pop;
          WRITE          = is_sw | is_push;
        end
        S_WB: begin
          CTRL           = hold;
          CTRL[PC_LOAD]  = 1'b1;
          CTRL[PC_SEL_1] = ~is_jr;
          CTRL[PC_SEL_2] = (is_beq & ZERO) | (is_bne & ~ZERO);
          CTRL[PC_SEL_3] = ~(is_jmp | is_jal);
          CTRL[REG_W]    = wr_rd | wr_rt | is_jal | is_pop;
          CTRL[WA_SEL_1] = wr_rt;
          CTRL[WA_SEL_2] = is_jal;
          CTRL[WA_SEL_3] = wr_rd | wr_rt;
          CTRL[WD_SEL_1] = is_lw | is_pop;
          CTRL[WD_SEL_2] = is_lui;
          CTRL[WD_SEL_3] = ~is_jal;
          CTRL[SP_LOAD]  = is_push;
        end
        S_HALT:  HALTED = 1'b1;
        default: CTRL = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: two instances (halting and NOP-on-illegal)
// share stimulus; a per-phase reference built from instruction semantics
// predicts every output each cycle.
module tb_control_unit_fsm;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ZERO = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic [31:0] ctrl_h, ctrl_n;
  logic        read_h, read_n, write_h, write_n, halted_h, halted_n;

  int n_checks = 0;
  int n_errors = 0;
  int ph_h = 0;
  int ph_n = 0;

  logic [31:0] obs_ctrl;
  logic        obs_read, obs_write, obs_halted;
  logic [31:0] oc [5];
  logic        orr [5];
  logic        ow [5];

  control_unit_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .CLK(CLK), .RST(RST), .ZERO(ZERO), .INSTRUCTION(INSTRUCTION),
    .CTRL(ctrl_h), .READ(read_h), .WRITE(write_h), .HALTED(halted_h));

  control_unit_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_n (
    .CLK(CLK), .RST(RST), .ZERO(ZERO), .INSTRUCTION(INSTRUCTION),
    .CTRL(ctrl_n), .READ(read_n), .WRITE(write_n), .HALTED(halted_n));

  always #5 CLK = ~CLK;

  typedef enum {K_ILL, K_RALU, K_SHIFT, K_JR, K_IMM_S, K_IMM_Z, K_LUI, K_BEQ,
                K_BNE, K_LW, K_SW, K_JMP, K_JAL, K_PUSH, K_POP} kind_e;

  function automatic logic [31:0] fb(input int n);
    return 32'(1) << n;
  endfunction

  // Instruction class and ALU operation from opcode/funct
  function automatic kind_e kind_of(input logic [31:0] ir, output int alu);
    logic [5:0] op, fn;
    op = ir[31:26];
    fn = ir[5:0];
    alu = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin alu = 1; return K_RALU; end
        6'h22: begin alu = 2; return K_RALU; end
        6'h2c: begin alu = 3; return K_RALU; end
        6'h24: begin alu = 6; return K_RALU; end
        6'h25: begin alu = 7; return K_RALU; end
        6'h27: begin alu = 8; return K_RALU; end
        6'h2a: begin alu = 9; return K_RALU; end
        6'h01: begin alu = 5; return K_SHIFT; end
        6'h02: begin alu = 4; return K_SHIFT; end
        6'h08: return K_JR;
        default: return K_ILL;
      endcase
    end
    case (op)
      6'h08: begin alu = 1; return K_IMM_S; end
      6'h1d: begin alu = 3; return K_IMM_S; end
      6'h0a: begin alu = 9; return K_IMM_S; end
      6'h0c: begin alu = 6; return K_IMM_Z; end
      6'h0d: begin alu = 7; return K_IMM_Z; end
      6'h0f: return K_LUI;
      6'h04: begin alu = 2; return K_BEQ; end
      6'h05: begin alu = 2; return K_BNE; end
      6'h23: begin alu = 1; return K_LW; end
      6'h2b: begin alu = 1; return K_SW; end
      6'h02: return K_JMP;
      6'h03: return K_JAL;
      6'h1b: begin alu = 2; return K_PUSH; end
      6'h1c: begin alu = 1; return K_POP; end
      default: return K_ILL;
    endcase
  endfunction

  // Expected outputs for a given phase (0..4, 7 = halted)
  function automatic void model(input int ph, input logic [31:0] ir, input logic zero,
                                input logic rst, output logic [31:0] c,
                                output logic rd, output logic wr, output logic hl);
    kind_e k;
    int alu;
    logic [31:0] opnd;
    logic taken;
    c = 0; rd = 0; wr = 0; hl = 0;
    if (rst) return;
    k = kind_of(ir, alu);
    // operand routing held EXE..WB
    opnd = 32'(alu) << 22;
    case (k)
      K_RALU:         opnd |= fb(21);
      K_SHIFT:        opnd |= fb(20) | fb(18);
      K_IMM_S, K_LW, K_SW: opnd |= fb(19);
      K_BEQ, K_BNE:   opnd |= fb(21) | fb(19);
      K_PUSH:         opnd |= fb(17) | fb(20) | fb(7) | fb(28);
      K_POP:          opnd |= fb(17) | fb(20);
      default:        opnd |= 0;
    endcase
    case (ph)
      0: begin c = fb(5) | fb(27); rd = 1; end
      1: begin c = fb(5) | fb(27) | fb(4) | fb(8); rd = 1; end
      2: begin c = opnd | fb(8); if (k == K_POP) c |= fb(16); end
      3: begin
        c = opnd;
        if (k == K_LW)   begin c |= fb(5);          rd = 1; end
        if (k == K_POP)  begin c |= fb(5) | fb(26); rd = 1; end
        if (k == K_SW)   begin c |= fb(6);          wr = 1; end
        if (k == K_PUSH) begin c |= fb(6) | fb(26); wr = 1; end
      end
      4: begin
        c = opnd | fb(0);
        taken = (k == K_BEQ && zero) || (k == K_BNE && !zero);
        if (k == K_JR) c |= fb(3);
        else if (k == K_JMP || k == K_JAL) c |= fb(1);
        else if (taken) c |= fb(1) | fb(2) | fb(3);
        else c |= fb(1) | fb(3);
        // destination register
        if (k == K_RALU || k == K_SHIFT) c |= fb(9) | fb(12);
        if (k == K_IMM_S || k == K_IMM_Z || k == K_LW || k == K_LUI) c |= fb(9) | fb(12) | fb(10);
        if (k == K_JAL) c |= fb(9) | fb(11);
        if (k == K_POP) c |= fb(9);
        // write data source
        if (k != K_JAL) c |= fb(15);
        if (k == K_LW || k == K_POP) c |= fb(13);
        if (k == K_LUI) c |= fb(14);
        if (k == K_PUSH) c |= fb(16);
      end
      default: hl = 1;
    endcase
  endfunction

  function automatic int next_ph(input int ph, input logic [31:0] ir, input bit halt_en);
    int alu;
    if (ph == 7) return 7;
    if (ph == 1 && halt_en && kind_of(ir, alu) == K_ILL) return 7;
    return (ph + 1) % 5;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check after settle, advance the model at posedge
  task automatic step(input logic rst, input logic [31:0] ir, input logic zero);
    logic [31:0] ec;
    logic er, ew, eh;
    RST = rst; INSTRUCTION = ir; ZERO = zero;
    #1;
    model(ph_h, ir, zero, rst, ec, er, ew, eh);
    check_eq("h.ctrl", ctrl_h, ec);
    check_eq("h.read", 32'(read_h), 32'(er));
    check_eq("h.write", 32'(write_h), 32'(ew));
    check_eq("h.halted", 32'(halted_h), 32'(eh));
    check_eq("h.rw_excl", 32'(read_h & write_h), 32'(0));
    if (!rst) check_eq("h.state", 32'(dut_h.state_q), 32'(ph_h));
    model(ph_n, ir, zero, rst, ec, er, ew, eh);
    check_eq("n.ctrl", ctrl_n, ec);
    check_eq("n.read", 32'(read_n), 32'(er));
    check_eq("n.write", 32'(write_n), 32'(ew));
    check_eq("n.halted", 32'(halted_n), 32'(eh));
    obs_ctrl = ctrl_h; obs_read = read_h; obs_write = write_h; obs_halted = halted_h;
    @(posedge CLK);
    ph_h = rst ? 0 : next_ph(ph_h, ir, 1'b1);
    ph_n = rst ? 0 : next_ph(ph_n, ir, 1'b0);
    @(negedge CLK);
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic zwb);
    for (int p = 0; p < 5; p++) begin
      step(1'b0, ir, (p == 4) ? zwb : 1'($urandom_range(0, 1)));
      oc[p] = obs_ctrl; orr[p] = obs_read; ow[p] = obs_write;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08};
    logic [5:0] ops [14] = '{6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h04, 6'h05,
                             6'h23, 6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c};
    logic [31:0] w;
    int sel;
    sel = $urandom_range(0, 9);
    w = $urandom;
    if (sel < 4) begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 9)]; end
    else if (sel < 8) w[31:26] = ops[$urandom_range(0, 13)];
    else if (sel == 8) w[31:26] = 6'h00;
    return w;
  endfunction

  initial begin
    logic [31:0] cur_ir;
    logic r;
    @(negedge CLK);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    check_eq("rst.ctrl", obs_ctrl, 32'h0);
    check_eq("rst.read", 32'(obs_read), 32'(0));

    run_instr(32'h00221820, 1'b0);
    check_eq("fetch.ctrl", oc[0], 32'h08000020);
    check_eq("fetch.read", 32'(orr[0]), 32'(1));
    check_eq("add.exe.alu", 32'(oc[2][25:22]), 32'(1));
    check_eq("add.exe.op2_sel_4", 32'(oc[2][21]), 32'(1));
    check_eq("add.wb.reg_w", 32'(oc[4][9]), 32'(1));
    check_eq("add.wb.wa_sel_3", 32'(oc[4][12]), 32'(1));
    check_eq("add.wb.wa_sel_1", 32'(oc[4][10]), 32'(0));
    check_eq("add.wb.pc_bits", 32'({oc[4][3], oc[4][1], oc[4][0]}), 32'(7));
    check_eq("add.strobes", 32'({orr[2], ow[2], orr[3], ow[3], orr[4], ow[4]}), 32'(0));

    run_instr(32'h10220003, 1'b1);
    check_eq("beq.z1.pc_sel_2", 32'(oc[4][2]), 32'(1));
    check_eq("beq.alu", 32'(oc[4][25:22]), 32'(2));
    run_instr(32'h10220003, 1'b0);
    check_eq("beq.z0.pc_sel_2", 32'(oc[4][2]), 32'(0));

    run_instr(32'hAC220004, 1'b0);
    check_eq("sw.mem.write", 32'(ow[3]), 32'(1));
    check_eq("sw.mem.mem_w", 32'(oc[3][6]), 32'(1));
    check_eq("sw.mem.ma_sel_2", 32'(oc[3][27]), 32'(0));
    check_eq("sw.mem.op2_sel_2", 32'(oc[3][19]), 32'(1));
    check_eq("sw.mem.alu", 32'(oc[3][25:22]), 32'(1));

    run_instr(32'h6C000000, 1'b0);
    check_eq("push.mem.write", 32'(ow[3]), 32'(1));
    check_eq("push.mem.sels", 32'({oc[3][26], oc[3][28], oc[3][7]}), 32'(7));
    check_eq("push.wb.sp_load", 32'(oc[4][16]), 32'(1));
    check_eq("push.wb.alu", 32'(oc[4][25:22]), 32'(2));

    run_instr(32'h0C000010, 1'b0);
    check_eq("jal.wb.pc_sel_3", 32'(oc[4][3]), 32'(0));
    check_eq("jal.wb.reg_w", 32'(oc[4][9]), 32'(1));
    check_eq("jal.wb.wa_sel_3", 32'(oc[4][12]), 32'(0));
    check_eq("jal.wb.wa_sel_2", 32'(oc[4][11]), 32'(1));
    check_eq("jal.wb.wd_sel_3", 32'(oc[4][15]), 32'(0));

    step(1'b0, 32'hFC000000, 1'b0);
    step(1'b0, 32'hFC000000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'hFC000000, 1'($urandom_range(0, 1)));
      check_eq("halt.halted", 32'(obs_halted), 32'(1));
      check_eq("halt.ctrl", obs_ctrl, 32'h0);
    end
    step(1'b1, 32'hFC000000, 1'b0);
    step(1'b0, 32'h00221820, 1'b0);
    check_eq("halt.exit.fetch", obs_ctrl, 32'h08000020);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h00221820, 1'b0);

    step(1'b0, 32'hAC220004, 1'b0);
    step(1'b0, 32'hAC220004, 1'b0);
    step(1'b0, 32'hAC220004, 1'b0);
    step(1'b1, 32'hAC220004, 1'b0);
    check_eq("sw.rst.write", 32'(obs_write), 32'(0));
    step(1'b0, 32'hAC220004, 1'b0);
    check_eq("sw.rst.fetch", obs_ctrl, 32'h08000020);
    for (int i = 0; i < 4; i++) step(1'b0, 32'hAC220004, 1'b0);

    cur_ir = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 39) == 0);
      if (ph_n == 0) cur_ir = rand_instr();
      step(r, cur_ir, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
